// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter: instruction cache (s0) and data cache (s1)
// share one external read port. Whole bursts are granted, AR handshake through the
// rlast beat, with round-robin on contention.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   sX_araddr/arlen/arvalid         requester read address channel (in)
//   sX_arready                      requester address accepted (out)
//   sX_rdata/rresp/rlast            read data, broadcast to both requesters (out)
//   sX_rvalid                       beat valid, granted requester only (out)
//   sX_rready                       requester beat accept (in)
//   m_ar*, m_r*                     single AXI4 read master port to memory
//   grant                           one-hot owner, 2'b00 when idle
//   busy                            a burst is in its address or data phase
module axi_rd_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]            s0_arlen,
    input  logic                  s0_arvalid,
    output logic                  s0_arready,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic [1:0]            s0_rresp,
    output logic                  s0_rlast,
    output logic                  s0_rvalid,
    input  logic                  s0_rready,
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]            s1_arlen,
    input  logic                  s1_arvalid,
    output logic                  s1_arready,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic [1:0]            s1_rresp,
    output logic                  s1_rlast,
    output logic                  s1_rvalid,
    input  logic                  s1_rready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [1:0]            grant,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    arb_state_e state_q, state_d;
    logic       grant_id_q, grant_id_d;
    logic       last_id_q, last_id_d;

    // rready of whichever requester currently owns the bus
    logic       sel_rready;
    assign sel_rready = grant_id_q ? s1_rready : s0_rready;

    // State register; last_id resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_IDLE;
            grant_id_q <= 1'b0;
            last_id_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
        end
    end

    // Next-state: arbitrate in idle, hold the grant until the rlast handshake
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        case (state_q)
            ARB_IDLE: begin
                if (s0_arvalid && s1_arvalid) begin
                    grant_id_d = ~last_id_q;
                    state_d    = ARB_ADDR;
                end else if (s0_arvalid) begin
                    grant_id_d = 1'b0;
                    state_d    = ARB_ADDR;
                end else if (s1_arvalid) begin
                    grant_id_d = 1'b1;
                    state_d    = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                // m_arvalid is unconditionally high in this state
                if (m_arready) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                // Burst length is not counted; only rlast releases the bus
                if (m_rvalid && sel_rready && m_rlast) begin
                    state_d   = ARB_IDLE;
                    last_id_d = grant_id_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Output steering: muxes on registered state and grant_id only
    always_comb begin
        m_arvalid  = 1'b0;
        m_araddr   = '0;
        m_arlen    = '0;
        m_rready   = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        s0_rvalid  = 1'b0;
        s1_rvalid  = 1'b0;
        grant      = 2'b00;
        busy       = 1'b0;
        case (state_q)
            ARB_ADDR: begin
                m_arvalid  = 1'b1;
                m_araddr   = grant_id_q ? s1_araddr : s0_araddr;
                m_arlen    = grant_id_q ? s1_arlen : s0_arlen;
                s0_arready = !grant_id_q && m_arready;
                s1_arready = grant_id_q && m_arready;
            end
            ARB_DATA: begin
                m_rready  = sel_rready;
                s0_rvalid = !grant_id_q && m_rvalid;
                s1_rvalid = grant_id_q && m_rvalid;
            end
            default: begin
            end
        endcase
        if (state_q != ARB_IDLE) begin
            busy  = 1'b1;
            grant = grant_id_q ? 2'b10 : 2'b01;
        end
    end

    // Data, response and last are broadcast; rvalid alone qualifies them
    assign s0_rdata = m_rdata;
    assign s1_rdata = m_rdata;
    assign s0_rresp = m_rresp;
    assign s1_rresp = m_rresp;
    assign s0_rlast = m_rlast;
    assign s1_rlast = m_rlast;

endmodule
